mem_read_arbiter: RTL and testbench

Round-robin read scheduler that shares the single combinational-read port of the CNN input/weight word memory among `NUM_REQ` burst requesters, e.g. the IFmap and filter buffer fillers. Each requester posts a start word address and a burst length. The block grants one request at a time, steps the memory address once per accepted beat, and registers each 32-bit word onto a shared tagged output stream with valid/ready flow control. It sits between the buffer fillers and the memory and is the only driver of the memory address and read-enable.

---
 rtl/mem_read_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin burst read scheduler for a single combinational-read word memory.
// Grants one requester at a time and streams its words out through a valid/ready register.
module mem_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 128,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mem_adr,
  output logic                      mem_w_r_en,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ID_W-1:0]           rd_id,
  output logic                      rd_last,
  input  logic                      rd_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ID_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [AW-1:0]     cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic              rd_last_q, rd_last_d;

  logic [AW-1:0]     start_addr [NUM_REQ];
  logic [LEN_W-1:0]  start_len  [NUM_REQ];
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [SW-1:0]     scan_sum;
  logic [ID_W-1:0]   scan_idx;
  logic              load;
  logic              addr_unused;

  // Only the low log2(DEPTH) address bits reach the memory.
  assign addr_unused = ^req_addr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      start_addr[i] = req_addr[i*ADDR_W +: AW];
      start_len[i]  = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Scan from the highest offset down so the nearest set bit above rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_q} + SW'(k);
      if (scan_sum >= SW'(NUM_REQ)) begin
        scan_sum = scan_sum - SW'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign load = (state_q == READ) && (!rd_valid_q || rd_ready);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_last_d  = rd_last_q;
    req_ready  = '0;
    mem_adr    = '0;
    mem_w_r_en = 1'b1;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Masked during reset so no requester drops a request that is never latched.
        if (grant_vld && !rst) begin
          req_ready[grant_idx] = 1'b1;
          cur_addr_d = start_addr[grant_idx];
          cnt_d      = start_len[grant_idx];
          cur_id_d   = grant_idx;
          rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
          state_d    = READ;
        end
      end
      READ: begin
        mem_adr    = ADDR_W'(cur_addr_q);
        mem_w_r_en = 1'b0;
        if (load) begin
          rd_data_d  = mem_read_data;
          rd_id_d    = cur_id_q;
          rd_last_d  = (cnt_q == '0);
          rd_valid_d = 1'b1;
          cur_addr_d = cur_addr_q + AW'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_mem_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 128;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         mem_adr;
  logic                      mem_w_r_en;
  logic [DATA_W-1:0]         mem_read_data;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ID_W-1:0]           rd_id;
  logic                      rd_last;
  logic                      rd_ready;

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int failures = 0;

  mem_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .mem_adr(mem_adr), .mem_w_r_en(mem_w_r_en), .mem_read_data(mem_read_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
    .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_adr[6:0]];

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input int addr, input int len);
    req_valid[i] = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_len[i*LEN_W +: LEN_W]    = LEN_W'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; rd_ready = 1'b0;
    next();
    post(1, 3, 0);
    sample();
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_no_grant: req_ready=%b want 0000", req_ready);
    end
    next();
    req_valid = '0;
    rst = 1'b0;
    sample();
    checks++;
    if ({rd_valid, rd_last, rd_id, rd_data, mem_adr, mem_w_r_en, req_ready} !==
        {1'b0, 1'b0, 2'd0, 32'd0, 10'd0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state: v=%b l=%b id=%0d d=%h adr=%0d wr=%b rr=%b", rd_valid, rd_last,
               rd_id, rd_data, mem_adr, mem_w_r_en, req_ready);
    end
    next();
  endtask

  task automatic test_single();
    rd_ready = 1'b1;
    post(1, 5, 3);
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL single_grant: req_ready=%b want 0010", req_ready);
    end
    next();
    req_valid = '0;
    sample();
    checks++;
    if ({mem_adr, mem_w_r_en, rd_valid} !== {10'd5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_addr: adr=%0d wr=%b v=%b want 5 0 0", mem_adr, mem_w_r_en, rd_valid);
    end
    next();
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if ({rd_valid, rd_id, rd_last, rd_data} !== {1'b1, 2'd1, (k == 3), mem[5+k]}) begin
        failures++;
        $display("FAIL single_beat%0d: v=%b id=%0d last=%b d=%h want id 1 d=%h", k, rd_valid,
                 rd_id, rd_last, rd_data, mem[5+k]);
      end
      next();
    end
    sample();
    checks++;
    if ({rd_valid, mem_w_r_en} !== 2'b01) begin
      failures++; $display("FAIL single_end: v=%b wr=%b want 0 1", rd_valid, mem_w_r_en);
    end
    next();
  endtask

  task automatic test_wrap();
    int wa;
    rd_ready = 1'b1;
    post(3, 510, 3);
    sample();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL wrap_grant: req_ready=%b want 1000", req_ready);
    end
    next();
    req_valid = '0;
    sample();
    checks++;
    if (mem_adr !== 10'd126) begin
      failures++; $display("FAIL wrap_start: adr=%0d want 126", mem_adr);
    end
    next();
    for (int k = 0; k < 4; k++) begin
      wa = (126 + k) % DEPTH;
      sample();
      checks++;
      if ({rd_valid, rd_id, rd_last, rd_data} !== {1'b1, 2'd3, (k == 3), mem[wa]}) begin
        failures++;
        $display("FAIL wrap_beat%0d: v=%b id=%0d last=%b d=%h want d=%h", k, rd_valid, rd_id,
                 rd_last, rd_data, mem[wa]);
      end
      next();
    end
    next();
  endtask

  task automatic test_backpressure();
    int a;
    logic [DATA_W:0] acc[$];
    a = $urandom_range(0, DEPTH-1);
    acc = {};
    post(0, a, 4);
    for (int c = 0; c < 10; c++) begin
      rd_ready = !(c == 3 || c == 4);
      if (c == 1) req_valid = '0;
      sample();
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          failures++; $display("FAIL bp_grant: req_ready=%b want 0001", req_ready);
        end
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, mem[(a+1)%DEPTH]}) begin
          failures++;
          $display("FAIL bp_hold_c%0d: v=%b d=%h want %h", c, rd_valid, rd_data, mem[(a+1)%DEPTH]);
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (mem_adr !== ADDR_W'((a+2)%DEPTH)) begin
          failures++; $display("FAIL bp_adr_c%0d: adr=%0d want %0d", c, mem_adr, (a+2)%DEPTH);
        end
      end
      if (rd_valid && rd_ready) acc.push_back({rd_last, rd_data});
      next();
    end
    checks++;
    if (acc.size() != 5) begin
      failures++; $display("FAIL bp_count: got %0d beats want 5", acc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acc[k] !== {(k == 4), mem[(a+k)%DEPTH]}) begin
          failures++;
          $display("FAIL bp_beat%0d: got %h want %h", k, acc[k], {(k == 4), mem[(a+k)%DEPTH]});
        end
      end
    end
  endtask

  task automatic test_fairness();
    int gcnt, vcnt, last_c;
    logic [NUM_REQ-1:0] want;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) post(i, i*8, 0);
    rd_ready = 1'b1;
    gcnt = 0; vcnt = 0; last_c = 0;
    for (int c = 0; c < 16; c++) begin
      sample();
      if (req_ready != '0) begin
        want = NUM_REQ'(1) << (gcnt % NUM_REQ);
        checks++;
        if (req_ready !== want) begin
          failures++; $display("FAIL fair_grant%0d: req_ready=%b want %b", gcnt, req_ready, want);
        end
        if (gcnt > 0) begin
          checks++;
          if (c - last_c != 2) begin
            failures++; $display("FAIL fair_spacing%0d: gap=%0d want 2", gcnt, c - last_c);
          end
        end
        last_c = c;
        gcnt++;
      end
      if (rd_valid) begin
        checks++;
        if ({rd_id, rd_last, rd_data} !== {2'(vcnt % NUM_REQ), 1'b1, mem[(vcnt % NUM_REQ)*8]}) begin
          failures++;
          $display("FAIL fair_beat%0d: id=%0d last=%b d=%h want id %0d", vcnt, rd_id, rd_last,
                   rd_data, vcnt % NUM_REQ);
        end
        vcnt++;
      end
      next();
    end
    checks++;
    if (gcnt != 8) begin
      failures++; $display("FAIL fair_count: got %0d grants want 8", gcnt);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) next();
  endtask

  task automatic test_reset_mid();
    int a;
    a = $urandom_range(0, DEPTH-1);
    do_reset();
    rd_ready = 1'b1;
    post(2, a, 7);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req_valid = '0;
      if (c == 4) rst = 1'b1;
      sample();
      if (c >= 2) begin
        checks++;
        if ({rd_valid, rd_last, rd_id, rd_data} !== {1'b1, 1'b0, 2'd2, mem[(a+c-2)%DEPTH]}) begin
          failures++;
          $display("FAIL rstmid_beat%0d: v=%b last=%b id=%0d d=%h", c-2, rd_valid, rd_last,
                   rd_id, rd_data);
        end
      end
      next();
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if ({rd_valid, rd_last, mem_w_r_en, mem_adr, req_ready} !== {1'b0, 1'b0, 1'b1, 10'd0, 4'b0000}) begin
        failures++;
        $display("FAIL rstmid_after%0d: v=%b last=%b wr=%b adr=%0d rr=%b", c, rd_valid, rd_last,
                 mem_w_r_en, mem_adr, req_ready);
      end
      next();
    end
    post(0, 9, 0);
    post(3, 20, 0);
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL rstmid_rrptr: req_ready=%b want 0001", req_ready);
    end
    next();
    req_valid = '0;
    next();
    sample();
    checks++;
    if ({rd_valid, rd_id, rd_last, rd_data} !== {1'b1, 2'd0, 1'b1, mem[9]}) begin
      failures++;
      $display("FAIL rstmid_regrant: v=%b id=%0d last=%b d=%h want %h", rd_valid, rd_id,
               rd_last, rd_data, mem[9]);
    end
    next();
    next();
  endtask

  task automatic test_back_to_back();
    int a, b;
    a = $urandom_range(0, DEPTH-1);
    b = $urandom_range(0, DEPTH-1);
    do_reset();
    rd_ready = 1'b0;
    post(0, a, 0);
    post(2, b, 1);
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL b2b_grant0: req_ready=%b want 0001", req_ready);
    end
    next();
    req_valid[0] = 1'b0;
    sample();
    checks++;
    if ({req_ready, rd_valid} !== {4'b0000, 1'b0}) begin
      failures++; $display("FAIL b2b_read0: rr=%b v=%b", req_ready, rd_valid);
    end
    next();
    sample();
    checks++;
    if ({req_ready, rd_valid, rd_id, rd_last, rd_data} !== {4'b0100, 1'b1, 2'd0, 1'b1, mem[a]}) begin
      failures++;
      $display("FAIL b2b_grant2: rr=%b v=%b id=%0d last=%b d=%h", req_ready, rd_valid, rd_id,
               rd_last, rd_data);
    end
    next();
    req_valid = '0;
    for (int c = 3; c < 5; c++) begin
      if (c == 4) rd_ready = 1'b1;
      sample();
      checks++;
      if ({rd_valid, rd_id, rd_data, mem_adr, mem_w_r_en} !== {1'b1, 2'd0, mem[a], ADDR_W'(b), 1'b0}) begin
        failures++;
        $display("FAIL b2b_hold_c%0d: v=%b id=%0d d=%h adr=%0d wr=%b", c, rd_valid, rd_id,
                 rd_data, mem_adr, mem_w_r_en);
      end
      next();
    end
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++;
      if ({rd_valid, rd_id, rd_last, rd_data} !== {1'b1, 2'd2, (k == 1), mem[(b+k)%DEPTH]}) begin
        failures++;
        $display("FAIL b2b_req2_beat%0d: v=%b id=%0d last=%b d=%h", k, rd_valid, rd_id,
                 rd_last, rd_data);
      end
      next();
    end
    sample();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_end: v=%b want 0", rd_valid);
    end
    next();
  endtask

  task automatic test_random();
    logic [DATA_W+ID_W:0] expq[$];
    logic [DATA_W+ID_W:0] e;
    bit pend [NUM_REQ];
    bit granted [NUM_REQ];
    int raddr [NUM_REQ];
    int rlen [NUM_REQ];
    int rr_m, idx, cyc;
    bit found, busy;
    logic [NUM_REQ-1:0] want;
    do_reset();
    rd_ready = 1'b0;
    expq = {};
    rr_m = 0;
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; granted[i] = 0; end
    cyc = 0;
    busy = 1;
    while (busy && cyc < 8000) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (granted[i]) begin
          pend[i] = 0;
          granted[i] = 0;
        end
        if (!pend[i] && cyc < 3000 && ($urandom % 4 == 0)) begin
          pend[i] = 1;
          raddr[i] = $urandom_range(0, 1023);
          rlen[i] = ($urandom % 32 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
        end
        req_valid[i] = pend[i];
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(raddr[i]);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(rlen[i]);
      end
      rd_ready = (cyc >= 3000) || ($urandom % 4 != 0);
      sample();
      if (req_ready != '0) begin
        found = 0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && pend[(rr_m + k) % NUM_REQ]) begin
            found = 1;
            idx = (rr_m + k) % NUM_REQ;
          end
        end
        want = found ? (NUM_REQ'(1) << idx) : '0;
        checks++;
        if (req_ready !== want) begin
          failures++; $display("FAIL rand_grant@%0d: req_ready=%b want %b", cyc, req_ready, want);
        end
        if (found) begin
          for (int k = 0; k <= rlen[idx]; k++) begin
            expq.push_back({(k == rlen[idx]), 2'(idx), mem[(raddr[idx] + k) % DEPTH]});
          end
          granted[idx] = 1;
          rr_m = (idx + 1) % NUM_REQ;
        end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++; $display("FAIL rand_extra@%0d: unexpected beat id=%0d d=%h", cyc, rd_id, rd_data);
        end else begin
          e = expq.pop_front();
          if ({rd_last, rd_id, rd_data} !== e) begin
            failures++;
            $display("FAIL rand_beat@%0d: got last=%b id=%0d d=%h want %h", cyc, rd_last,
                     rd_id, rd_data, e);
          end
        end
      end
      next();
      cyc++;
      busy = (cyc < 3000) || (expq.size() != 0);
      for (int i = 0; i < NUM_REQ; i++) if (pend[i] && !granted[i]) busy = 1;
    end
    checks++;
    if (busy) begin
      failures++; $display("FAIL rand_drain: %0d beats outstanding at cycle %0d", expq.size(), cyc);
    end
    req_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
